muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 93 +++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULTU/DIVU unit with architectural HI/LO; define MULDIV_EARLY_OUT_EN for multiply early-out
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] sh_acc, sh_op, mul_acc_n;
  logic [WIDTH-1:0] sh_q, div_sub, rem_n, q_n;
  logic [WIDTH:0] div_sh;
  logic accept, div_ge, div_zero, mul_last;
  assign accept = (state == IDLE || state == DONE) && start;
  // multiply: sh_op is the left-shifting multiplicand, sh_q the right-shifting multiplier
  assign mul_acc_n = sh_acc + (sh_q[0] ? sh_op : '0);
  // divide: sh_acc low half is the remainder, sh_q shifts dividend out and quotient in
  assign div_sh = {sh_acc[WIDTH-1:0], sh_q[WIDTH-1]};
  assign div_ge = div_sh >= {1'b0, sh_op[WIDTH-1:0]};
  assign div_sub = div_sh[WIDTH-1:0] - sh_op[WIDTH-1:0];
  assign rem_n = div_ge ? div_sub : div_sh[WIDTH-1:0];
  assign q_n = {sh_q[WIDTH-2:0], div_ge};
  assign div_zero = sh_op[WIDTH-1:0] == '0;
`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = cnt == '0 || sh_q[WIDTH-1:1] == '0;
`else
  assign mul_last = cnt == '0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? (op ? DIV : MUL) : IDLE;
      MUL: state_n = flush ? IDLE : mul_last ? DONE : MUL;
      DIV: state_n = flush ? IDLE : (div_zero || cnt == '0) ? DONE : DIV;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy = state == MUL || state == DIV;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sh_acc <= '0;
      sh_op <= '0;
      sh_q <= '0;
      hi <= '0;
      lo <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt <= CW'(WIDTH - 1);
      sh_acc <= '0;
      sh_op <= {{WIDTH{1'b0}}, op ? b : a};
      sh_q <= op ? a : b;
      div_by_zero <= 1'b0;
    end else if (state == MUL && !flush) begin
      cnt <= cnt - 1'b1;
      sh_acc <= mul_acc_n;
      sh_op <= sh_op << 1;
      sh_q <= sh_q >> 1;
      if (mul_last) {hi, lo} <= mul_acc_n;
    end else if (state == DIV && !flush) begin
      cnt <= cnt - 1'b1;
      sh_acc <= {{WIDTH{1'b0}}, rem_n};
      sh_q <= q_n;
      if (div_zero) begin
        hi <= sh_q;
        lo <= '1;
        div_by_zero <= 1'b1;
      end else if (cnt == '0) begin
        hi <= rem_n;
        lo <= q_n;
      end
    end
  end
endmodule
